// File: rtl/dphy_hs_rx_lane.sv
// D-PHY data-lane HS receive controller: LP-11 -> LP-01 -> LP-00 entry, HS-settle, sync hunt, byte deserialization.
// Optional DPHY_RX_SOT_1BIT_EN: accept a sync byte with a single-bit error, flagged on err_sot.
module dphy_hs_rx_lane #(
  parameter int unsigned SETTLE_CYCLES = 6,
  parameter int unsigned SYNC_TIMEOUT  = 31,
  parameter logic [7:0]  SYNC_BYTE     = 8'hB8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lp_dp,
  input  logic       lp_dn,
  input  logic       hs_bit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_sync,
  output logic       stop_state,
  output logic       err_control,
  output logic       err_sot_sync,
  output logic       err_sot
);

  // state | meaning: STOP LP-11 idle | HS_RQST LP-01 seen | SETTLE LP-00 settle timer
  // HUNT sync search | RECEIVE byte deserialization | ERR_WAIT sync timed out, wait for LP-11
  typedef enum logic [2:0] {
    ST_STOP, ST_HS_RQST, ST_SETTLE, ST_HUNT, ST_RECEIVE, ST_ERR_WAIT
  } state_t;

  localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYCLES - 1);
  localparam logic [4:0] TIMEOUT     = 5'(SYNC_TIMEOUT);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_sync_q, rx_sync_d;
  logic       err_control_q, err_control_d;
  logic       err_sot_sync_q, err_sot_sync_d;
  logic [1:0] lp;
  logic [7:0] sr_shift;
  logic       bits_full;
  logic       exact;
`ifdef DPHY_RX_SOT_1BIT_EN
  logic       err_sot_q, err_sot_d;
  logic [7:0] diff;
  logic       near;
`endif

  always_comb begin
    lp             = {lp_dp, lp_dn};
    sr_shift       = {hs_bit, sr_q[7:1]};
    bits_full      = (bit_cnt_q >= 4'd7);  // current bit makes it at least 8
    exact          = (sr_shift == SYNC_BYTE);
`ifdef DPHY_RX_SOT_1BIT_EN
    diff           = sr_shift ^ SYNC_BYTE;
    near           = (diff != 8'd0) && ((diff & (diff - 8'd1)) == 8'd0);
    err_sot_d      = 1'b0;
`endif
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_cnt_d      = bit_cnt_q;
    sr_d           = sr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_sync_d      = 1'b0;
    err_control_d  = 1'b0;
    err_sot_sync_d = 1'b0;

    case (state_q)
      ST_STOP: begin
        if (lp == 2'b01) state_d = ST_HS_RQST;
      end
      ST_HS_RQST: begin
        case (lp)
          2'b01: state_d = ST_HS_RQST;
          2'b00: begin
            state_d = ST_SETTLE;
            cnt_d   = 5'd0;
          end
          2'b11: state_d = ST_STOP;
          default: begin
            state_d       = ST_STOP;
            err_control_d = 1'b1;
          end
        endcase
      end
      ST_SETTLE: begin
        if (lp != 2'b00) begin
          state_d       = ST_STOP;
          err_control_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d   = ST_HUNT;
          cnt_d     = 5'd0;
          bit_cnt_d = 4'd0;
          sr_d      = 8'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_HUNT: begin
        if (lp != 2'b00) begin
          state_d       = ST_STOP;
          err_control_d = 1'b1;
        end else begin
          sr_d      = sr_shift;
          bit_cnt_d = bits_full ? 4'd8 : bit_cnt_q + 4'd1;
          cnt_d     = cnt_q + 5'd1;
          if (bits_full && exact) begin
            state_d   = ST_RECEIVE;
            rx_sync_d = 1'b1;
            bit_cnt_d = 4'd0;
`ifdef DPHY_RX_SOT_1BIT_EN
          end else if (bits_full && near) begin
            state_d   = ST_RECEIVE;
            rx_sync_d = 1'b1;
            err_sot_d = 1'b1;
            bit_cnt_d = 4'd0;
`endif
          end else if ((cnt_q + 5'd1) == TIMEOUT) begin
            state_d        = ST_ERR_WAIT;
            err_sot_sync_d = 1'b1;
          end
        end
      end
      ST_RECEIVE: begin
        case (lp)
          2'b00: begin
            sr_d = sr_shift;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = sr_shift;
              rx_valid_d = 1'b1;
              bit_cnt_d  = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          2'b11: begin
            state_d   = ST_STOP;  // partial byte dropped
            bit_cnt_d = 4'd0;
          end
          default: begin
            state_d       = ST_STOP;
            err_control_d = 1'b1;
            bit_cnt_d     = 4'd0;
          end
        endcase
      end
      ST_ERR_WAIT: begin
        if (lp == 2'b11) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_STOP;
      cnt_q          <= 5'd0;
      bit_cnt_q      <= 4'd0;
      sr_q           <= 8'd0;
      rx_data_q      <= 8'd0;
      rx_valid_q     <= 1'b0;
      rx_sync_q      <= 1'b0;
      err_control_q  <= 1'b0;
      err_sot_sync_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      sr_q           <= sr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_sync_q      <= rx_sync_d;
      err_control_q  <= err_control_d;
      err_sot_sync_q <= err_sot_sync_d;
    end
  end

`ifdef DPHY_RX_SOT_1BIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_sot_q <= 1'b0;
    else       err_sot_q <= err_sot_d;
  end
  assign err_sot = err_sot_q;
`else
  assign err_sot = 1'b0;
`endif

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_sync      = rx_sync_q;
  assign err_control  = err_control_q;
  assign err_sot_sync = err_sot_sync_q;
  assign rx_active    = (state_q == ST_RECEIVE);
  assign stop_state   = (state_q == ST_STOP);

endmodule
